// File: rtl/o_feature_store_if.sv
// rtl/o_feature_store_if.sv - command, buffer-read and external-write signals of the output feature store
interface o_feature_store_if #(
  parameter int DATA_BUS_WIDTH = 128,
  parameter int EXT_ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH      = 8
);
  logic                      store_enable;
  logic [MEM_ADDR_WIDTH-1:0] src_addr;
  logic [EXT_ADDR_WIDTH-1:0] dst_addr;
  logic [CNT_WIDTH-1:0]      store_counter;
  logic                      mem_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_BUS_WIDTH-1:0] mem_rd_data;
  logic [DATA_BUS_WIDTH-1:0] o_data_bus_port;
  logic [EXT_ADDR_WIDTH-1:0] o_feature_addr;
  logic                      o_feature_wr_en;
  logic                      o_feature_wr_ready;
  logic                      busy;
  logic                      store_done;

  modport slave (
    input  store_enable, src_addr, dst_addr, store_counter, mem_rd_data, o_feature_wr_ready,
    output mem_rd_en, mem_rd_addr, o_data_bus_port, o_feature_addr, o_feature_wr_en,
           busy, store_done
  );

  modport master (
    output store_enable, src_addr, dst_addr, store_counter, mem_rd_data, o_feature_wr_ready,
    input  mem_rd_en, mem_rd_addr, o_data_bus_port, o_feature_addr, o_feature_wr_en,
           busy, store_done
  );
endinterface

// File: rtl/o_feature_store.sv
// rtl/o_feature_store.sv - streams N output-buffer lines to consecutive external addresses
module o_feature_store #(
  parameter int DATA_BUS_WIDTH = 128,
  parameter int EXT_ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int CNT_WIDTH      = 8
) (
  input logic               clk,
  input logic               rst,
  o_feature_store_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_nx;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr;
  logic [EXT_ADDR_WIDTH-1:0] wr_addr;
  logic [CNT_WIDTH-1:0]      count, reads_issued, beats_done;
  logic                      rd_pending;
  logic [DATA_BUS_WIDTH-1:0] fifo_mem [2];
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                occ;
  logic                      rd_en, push, pop, last_beat, start;

  // Reads are throttled so buffered plus in-flight lines never exceed the 2 FIFO slots.
  always_comb begin
    start     = (state == IDLE) && bus.store_enable;
    push      = rd_pending;
    pop       = (occ != 2'd0) && bus.o_feature_wr_ready;
    rd_en     = (state == RUN) && (reads_issued < count) &&
                (({1'b0, occ} + {2'b0, rd_pending} - {2'b0, pop}) < 3'd2);
    last_beat = pop && (beats_done == count - 1'b1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.store_enable) state_nx = (bus.store_counter == '0) ? DONE : RUN;
      RUN:  if (last_beat) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en       = rd_en;
    bus.mem_rd_addr     = rd_en ? rd_addr : '0;
    bus.o_feature_wr_en = (occ != 2'd0);
    bus.o_data_bus_port = (occ != 2'd0) ? fifo_mem[rd_ptr] : '0;
    bus.o_feature_addr  = (occ != 2'd0) ? wr_addr : '0;
    bus.busy            = (state != IDLE);
    bus.store_done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr      <= '0;
      wr_addr      <= '0;
      count        <= '0;
      reads_issued <= '0;
      beats_done   <= '0;
      rd_pending   <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= 2'd0;
    end else begin
      state      <= state_nx;
      rd_pending <= rd_en;
      occ        <= occ + {1'b0, push} - {1'b0, pop};
      if (start) begin
        rd_addr      <= bus.src_addr;
        wr_addr      <= bus.dst_addr;
        count        <= bus.store_counter;
        reads_issued <= '0;
        beats_done   <= '0;
      end
      if (rd_en) begin
        rd_addr      <= rd_addr + 1'b1;
        reads_issued <= reads_issued + 1'b1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        wr_addr    <= wr_addr + 1'b1;
        beats_done <= beats_done + 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rd_data;
  end
endmodule

// File: tb/tb_o_feature_store.sv
// tb/tb_o_feature_store.sv - scoreboard bench for o_feature_store
module tb_o_feature_store;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  int   issued, accepted, done_cnt;
  bit   bp_mode = 1'b0;
  bit   stall_prev = 1'b0;
  logic [127:0] prev_data;
  logic [15:0]  prev_addr;

  logic [7:0]   exp_rd [$];
  logic [15:0]  exp_wa [$];
  logic [127:0] exp_wd [$];

  o_feature_store_if bus ();

  o_feature_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] line_data(input logic [7:0] a);
    return {16{a}};
  endfunction

  // Output buffer model: 1-cycle read latency.
  always @(posedge clk) begin
    if (rst) bus.mem_rd_data <= '0;
    else if (bus.mem_rd_en) bus.mem_rd_data <= line_data(bus.mem_rd_addr);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  // Ready pattern 1,0,0,1,0,1 repeating when backpressure is on.
  initial begin
    int idx = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.o_feature_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus.o_feature_wr_ready = pat[idx % 6];
        idx++;
      end else begin
        bus.o_feature_wr_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.mem_rd_en) begin
        issued++;
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", bus.mem_rd_addr, exp_rd.pop_front());
      end
      if (bus.o_feature_wr_en) begin
        if (stall_prev) begin
          check("hold_data", bus.o_data_bus_port, prev_data);
          check("hold_addr", bus.o_feature_addr, prev_addr);
        end
        if (bus.o_feature_wr_ready) begin
          accepted++;
          if (exp_wa.size() == 0) check("wr_unexpected", 1, 0);
          else begin
            check("wr_addr", bus.o_feature_addr, exp_wa.pop_front());
            check("wr_data", bus.o_data_bus_port, exp_wd.pop_front());
          end
        end
      end
      if (bus.mem_rd_en) check("outstanding_le2", (issued - accepted) <= 2, 1);
      stall_prev = bus.o_feature_wr_en && !bus.o_feature_wr_ready;
      prev_data  = bus.o_data_bus_port;
      prev_addr  = bus.o_feature_addr;
      if (bus.store_done) done_cnt++;
    end
  end

  task automatic start(input logic [7:0] src, input logic [15:0] dst, input logic [7:0] cnt);
    @(posedge clk);
    #1;
    bus.src_addr      = src;
    bus.dst_addr      = dst;
    bus.store_counter = cnt;
    bus.store_enable  = 1'b1;
    t0       = cyc;
    issued   = 0;
    accepted = 0;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_rd.push_back(8'(src + 8'(i)));
      exp_wa.push_back(16'(dst + 16'(i)));
      exp_wd.push_back(line_data(8'(src + 8'(i))));
    end
    @(posedge clk);
    #1;
    bus.store_enable = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.store_done && n < 300);
    check(tag, bus.store_done, 1);
    repeat (2) @(negedge clk);
    check({tag, "_sb_left"}, exp_wa.size() + exp_rd.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, bus.mem_rd_en, 0);
    check({tag, "_rd_addr"}, bus.mem_rd_addr, 0);
    check({tag, "_wr_en"}, bus.o_feature_wr_en, 0);
    check({tag, "_wr_data"}, bus.o_data_bus_port, 0);
    check({tag, "_wr_addr"}, bus.o_feature_addr, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.store_done, 0);
  endtask

  initial begin
    int d0;
    bus.store_enable  = 1'b0;
    bus.src_addr      = '0;
    bus.dst_addr      = '0;
    bus.store_counter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic streaming with cycle-exact timeline
    start(8'h10, 16'h2000, 8'd4);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      check($sformatf("basic_rd_en_c%0d", j), bus.mem_rd_en, (j >= 1 && j <= 4));
      check($sformatf("basic_wr_en_c%0d", j), bus.o_feature_wr_en, (j >= 3 && j <= 6));
      check($sformatf("basic_done_c%0d", j), bus.store_done, (j == 7));
      check($sformatf("basic_busy_c%0d", j), bus.busy, (j >= 1 && j <= 7));
    end
    check("basic_sb_left", exp_wa.size(), 0);

    // Backpressure
    bp_mode = 1'b1;
    start(8'h30, 16'h2000, 8'd6);
    wait_done("bp_done");
    check("bp_beats", accepted, 6);
    bp_mode = 1'b0;

    // Zero length
    start(8'h00, 16'h3000, 8'd0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check($sformatf("zero_rd_en_c%0d", j), bus.mem_rd_en, 0);
      check($sformatf("zero_wr_en_c%0d", j), bus.o_feature_wr_en, 0);
      check($sformatf("zero_busy_c%0d", j), bus.busy, (j == 1));
      check($sformatf("zero_done_c%0d", j), bus.store_done, (j == 1));
    end

    // Wrap-around of both address counters
    start(8'hFE, 16'hFFFF, 8'd3);
    wait_done("wrap_done");

    // Command while busy is ignored
    d0 = done_cnt;
    start(8'h50, 16'h2000, 8'd4);
    @(posedge clk);
    #1;
    bus.src_addr      = 8'h77;
    bus.dst_addr      = 16'h5000;
    bus.store_counter = 8'd9;
    bus.store_enable  = 1'b1;
    @(posedge clk);
    #1;
    bus.store_enable  = 1'b0;
    wait_done("busy_cmd_done");
    repeat (3) @(negedge clk);
    check("busy_cmd_beats", accepted, 4);
    check("busy_cmd_done_pulses", done_cnt - d0, 1);

    // Reset mid-store, then a fresh store
    d0 = done_cnt;
    start(8'h40, 16'h2000, 8'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (4) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    start(8'h60, 16'h0100, 8'd2);
    wait_done("after_rst_done");
    check("after_rst_beats", accepted, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/o_feature_store.md
Name: o_feature_store

Overview:
- Instruction-driven write-back engine, the outbound counterpart of the input feature fetcher.
- On a store command it reads N 128-bit lines from the on-chip output feature buffer, which has 1-cycle read latency.
- It streams them to the external data bus port at consecutive external addresses, with valid/ready backpressure.
- It reports completion to the top FSM through a done pulse.

Parameters:
- DATA_BUS_WIDTH, 128, width of a buffer line and of the external bus beat.
- EXT_ADDR_WIDTH, 16, external (DDR-side) line address width.
- MEM_ADDR_WIDTH, 8, on-chip output buffer line address width.
- CNT_WIDTH, 8, store length width, in lines.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- store_enable  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  MEM_ADDR_WIDTH  first on-chip buffer line to read.
- dst_addr  in  EXT_ADDR_WIDTH  first external line address to write.
- store_counter  in  CNT_WIDTH  number of lines to store; 0 is legal.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  MEM_ADDR_WIDTH  buffer read address.
- mem_rd_data  in  DATA_BUS_WIDTH  buffer data, valid the cycle after mem_rd_en.
- o_data_bus_port  out  DATA_BUS_WIDTH  external write data.
- o_feature_addr  out  EXT_ADDR_WIDTH  external write address.
- o_feature_wr_en  out  1  write valid.
- o_feature_wr_ready  in  1  external ready; a beat transfers when wr_en && ready.
- busy  out  1  command in progress.
- store_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal 2-entry buffer emptied; in-flight read data discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - store_enable=1 latches src, dst, count (cycle 0) and goes to RUN.
  - If count==0, it goes to DONE instead.
- RUN:
  - Read issue: mem_rd_en=1 when reads_issued < count and (buffer occupancy + in-flight reads − pop this cycle) < 2.
  - mem_rd_addr starts at src and increments by 1 per issued read, wrapping 0xFF→0x00.
  - Returned data is pushed into a 2-entry FIFO.
  - The FIFO head drives o_data_bus_port/o_feature_addr, and o_feature_wr_en = FIFO not empty.
  - Data and address are held stable while wr_en=1 and ready=0.
  - o_feature_addr starts at dst and increments by 1 per accepted beat, wrapping 0xFFFF→0x0000.
  - Leave for DONE on the cycle the final beat is accepted.
- DONE: store_done=1 for exactly one cycle, then IDLE.
- busy: 1 in RUN and DONE, 0 in IDLE.
- Latency with ready held high and store_enable at cycle 0:
  - mem_rd_en cycles 1..N;
  - o_feature_wr_en cycles 3..N+2;
  - store_done cycle N+3;
  - sustained 1 beat/cycle.
- count==0: no reads, no writes; busy and store_done both high in cycle 1.
- Backpressure: with ready=0, at most 2 lines are buffered and reads stall. No beat is lost or duplicated. Order is preserved.
- store_enable while busy (including the DONE cycle) is ignored; latched parameters are unchanged.
- rst mid-operation: immediate return to IDLE, outputs 0 the next cycle, no store_done pulse.
- Counters are CNT_WIDTH wide; max count 255.

Test Plan:
- Basic streaming: src=0x10, dst=0x2000, count=4, ready=1, mem returns line index → mem_rd_en cycles 1–4 (addr 0x10–0x13); writes cycles 3–6 (addr 0x2000–0x2003, data in order); store_done cycle 7; busy cycles 1–7.
- Backpressure: count=6, ready toggled 1,0,0,1,0,1… → exactly 6 beats, addr 0x2000–0x2005 in order; data stable during every wr_en && !ready cycle; never more than 2 reads outstanding beyond the accepted beats.
- Zero length: count=0 → mem_rd_en and wr_en never assert; busy=store_done=1 in cycle 1 only.
- Wrap-around: src=0xFE, dst=0xFFFF, count=3 → read addr 0xFE, 0xFF, 0x00; write addr 0xFFFF, 0x0000, 0x0001.
- Command while busy: second store_enable (dst=0x5000) at cycle 2 of a count=4 store → ignored; only 4 beats to 0x2000–0x2003; one store_done.
- Reset mid-store: rst at cycle 4 of a count=8 store → next cycle all outputs 0, busy=0, no store_done; a new count=2 store afterwards completes normally.
